// File: rtl/dm_sba_ctrl.sv
// System Bus Access manager for the RISC-V debug module: owns sbcs/sbaddress0/sbdata0
// and runs single 8/16/32-bit bus transactions. Optional bus timeout: define SBA_TIMEOUT_EN.
module dm_sba_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmi_valid,
  input  logic              dmi_write,
  input  logic [7:0]        dmi_addr,
  input  logic [31:0]       dmi_wdata,
  output logic [31:0]       dmi_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_size,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata,
  output logic              sb_busy
);

  localparam logic [7:0] ADDR_SBCS   = 8'h38;
  localparam logic [7:0] ADDR_SBADDR = 8'h39;
  localparam logic [7:0] ADDR_SBDATA = 8'h3c;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state, state_next;
  logic [ADDR_W-1:0] sb_address, start_addr_val;
  logic [31:0]       sb_data, rdata_ext, addr_ext;
  logic              readonaddr, autoincrement, readondata, busyerror, busyerror_next;
  logic [2:0]        access, error, error_next, err_val;
  logic              busy, go, err_set, misaligned, ack_ok;
  logic              wr_sbcs, wr_addr, wr_data, rd_data;
  logic              start_addr, start_wdata, start_rdata;

  assign busy    = (state == BUSY);
  assign sb_busy = busy;
  assign wr_sbcs = dmi_valid &  dmi_write & (dmi_addr == ADDR_SBCS);
  assign wr_addr = dmi_valid &  dmi_write & (dmi_addr == ADDR_SBADDR);
  assign wr_data = dmi_valid &  dmi_write & (dmi_addr == ADDR_SBDATA);
  assign rd_data = dmi_valid & ~dmi_write & (dmi_addr == ADDR_SBDATA);

  assign start_addr  = wr_addr & ~busy & readonaddr;
  assign start_wdata = wr_data & ~busy;
  assign start_rdata = rd_data & ~busy & readondata;
  assign ack_ok      = busy & bus_ack & ~bus_err;

  assign start_addr_val = wr_addr ? dmi_wdata[ADDR_W-1:0] : sb_address;
  assign misaligned = ((access == 3'd1) &  start_addr_val[0]) |
                      ((access == 3'd2) & |start_addr_val[1:0]);

`ifdef SBA_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    go         = 1'b0;
    err_set    = 1'b0;
    err_val    = 3'd0;
    unique case (state)
      IDLE: begin
        if ((start_addr | start_wdata | start_rdata) && (error == 3'd0) && !busyerror) begin
          if (access > 3'd2) begin
            err_set = 1'b1;
            err_val = 3'd4;
          end else if (misaligned) begin
            err_set = 1'b1;
            err_val = 3'd3;
          end else begin
            go         = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_err) begin
          err_set    = 1'b1;
          err_val    = 3'd2;
          state_next = IDLE;
        end else if (bus_ack) begin
          state_next = IDLE;
`ifdef SBA_TIMEOUT_EN
        end else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          err_set    = 1'b1;
          err_val    = 3'd1;
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase

    // A freshly generated error overrides a same-cycle write-1-to-clear.
    error_next = wr_sbcs ? (error & ~dmi_wdata[14:12]) : error;
    if (err_set) error_next = err_val;
    busyerror_next = (wr_sbcs ? (busyerror & ~dmi_wdata[22]) : busyerror) |
                     (busy & (wr_addr | wr_data | rd_data));
  end

  always_comb begin
    rdata_ext = 32'd0;
    unique case (bus_size)
      2'd0:    rdata_ext = {24'd0, bus_rdata[7:0]};
      2'd1:    rdata_ext = {16'd0, bus_rdata[15:0]};
      default: rdata_ext = bus_rdata;
    endcase
  end

  always_comb begin
    addr_ext               = 32'd0;
    addr_ext[ADDR_W-1:0]   = sb_address;
    dmi_rdata              = 32'd0;
    if (dmi_valid) begin
      unique case (dmi_addr)
        ADDR_SBCS:   dmi_rdata = {3'd1, 6'd0, busyerror, busy, readonaddr, access,
                                  autoincrement, readondata, error, 7'd32, 5'b00111};
        ADDR_SBADDR: dmi_rdata = addr_ext;
        ADDR_SBDATA: dmi_rdata = sb_data;
        default:     dmi_rdata = 32'd0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_address    <= '0;
      sb_data       <= 32'd0;
      readonaddr    <= 1'b0;
      access        <= 3'd2;
      autoincrement <= 1'b0;
      readondata    <= 1'b0;
      error         <= 3'd0;
      busyerror     <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_size      <= 2'd0;
      bus_wdata     <= 32'd0;
    end else begin
      error     <= error_next;
      busyerror <= busyerror_next;
      bus_req   <= (state_next == BUSY);
      if (wr_sbcs) begin
        readonaddr    <= dmi_wdata[20];
        access        <= dmi_wdata[19:17];
        autoincrement <= dmi_wdata[16];
        readondata    <= dmi_wdata[15];
      end
      if (wr_addr && !busy)
        sb_address <= dmi_wdata[ADDR_W-1:0];
      else if (ack_ok && autoincrement)
        sb_address <= sb_address + (ADDR_W'(1) << bus_size);
      if (wr_data && !busy)
        sb_data <= dmi_wdata;
      else if (ack_ok && !bus_we)
        sb_data <= rdata_ext;
      // Bus qualifiers are captured at start so sbcs writes during BUSY cannot disturb them.
      if (go) begin
        bus_we    <= start_wdata;
        bus_addr  <= start_addr_val;
        bus_size  <= access[1:0];
        bus_wdata <= wr_data ? dmi_wdata : sb_data;
      end
    end
  end

`ifdef SBA_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || go) tmo_cnt <= 32'd0;
    else if (busy) tmo_cnt <= tmo_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Scoreboard bench for dm_sba_ctrl: directed DMI/bus sequences, expected bus cycles and
// DMI read values queued by the stimulus and compared by an independent monitor.
module tb_dm_sba_ctrl;

  localparam logic [7:0] SBCS = 8'h38, SBADDR = 8'h39, SBDATA = 8'h3c;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        dmi_valid = 1'b0, dmi_write = 1'b0;
  logic [7:0]  dmi_addr = 8'd0;
  logic [31:0] dmi_wdata = 32'd0, dmi_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [1:0]  bus_size;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        sb_busy;

  int n_checks = 0, n_pass = 0;
  bus_exp_t    exp_bus[$];
  logic [31:0] exp_rd[$];
  bus_exp_t    cur;
  logic        have_cur = 1'b0, req_q = 1'b0;

  dm_sba_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .dmi_valid(dmi_valid), .dmi_write(dmi_write), .dmi_addr(dmi_addr),
    .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a bus cycle or DMI read data.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req && !req_q) begin
        check("bus_req expected", 64'(exp_bus.size() != 0), 64'd1);
        if (exp_bus.size() != 0) begin
          cur      = exp_bus.pop_front();
          have_cur = 1'b1;
        end
      end
      if (bus_req && have_cur) begin
        check("bus_we",   64'(bus_we),   64'(cur.we));
        check("bus_addr", 64'(bus_addr), 64'(cur.addr));
        check("bus_size", 64'(bus_size), 64'(cur.size));
        if (cur.we) check("bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
      end
      if (dmi_valid && !dmi_write) begin
        check("dmi read expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) check("dmi_rdata", 64'(dmi_rdata), 64'(exp_rd.pop_front()));
      end
    end
    req_q <= bus_req;
  end

  task automatic dmi_wr(input logic [7:0] a, input logic [31:0] d);
    dmi_valid = 1'b1; dmi_write = 1'b1; dmi_addr = a; dmi_wdata = d;
    @(posedge clk); #1;
    dmi_valid = 1'b0; dmi_write = 1'b0;
  endtask

  task automatic dmi_rd(input logic [7:0] a, input logic [31:0] exp);
    exp_rd.push_back(exp);
    dmi_valid = 1'b1; dmi_write = 1'b0; dmi_addr = a;
    @(posedge clk); #1;
    dmi_valid = 1'b0;
  endtask

  task automatic expect_bus(input logic we, input logic [31:0] a, input logic [1:0] s,
                            input logic [31:0] d);
    bus_exp_t e;
    e.we = we; e.addr = a; e.size = s; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  // Respond after 'delay' extra cycles of bus_req, then confirm the request has dropped.
  task automatic respond(input int delay, input logic ack, input logic err, input logic [31:0] rd);
    repeat (delay) begin @(posedge clk); #1; end
    bus_ack = ack; bus_err = err; bus_rdata = rd;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0;
    check("bus_req dropped", 64'(bus_req), 64'd0);
    check("sb_busy idle",    64'(sb_busy), 64'd0);
    have_cur = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset bus_req",   64'(bus_req),   64'd0);
    check("reset bus_addr",  64'(bus_addr),  64'd0);
    check("reset sb_busy",   64'(sb_busy),   64'd0);
    check("reset dmi_rdata", 64'(dmi_rdata), 64'd0);
    dmi_rd(SBCS,   32'h2004_0407);
    dmi_rd(SBADDR, 32'h0);
    dmi_rd(SBDATA, 32'h0);

    // Word write with autoincrement, ack after 3 cycles of bus_req.
    dmi_wr(SBCS, 32'h0005_0000);
    dmi_wr(SBADDR, 32'h0000_1000);
    expect_bus(1'b1, 32'h1000, 2'd2, 32'hDEAD_BEEF);
    dmi_wr(SBDATA, 32'hDEAD_BEEF);
    check("write start latency", 64'(bus_req), 64'd1);
    respond(2, 1'b1, 1'b0, 32'h0);
    dmi_rd(SBADDR, 32'h0000_1004);
    dmi_rd(SBCS,   32'h2005_0407);

    // Byte read on address write, zero-wait ack.
    dmi_wr(SBCS, 32'h0010_0000);
    expect_bus(1'b0, 32'h2003, 2'd0, 32'h0);
    dmi_wr(SBADDR, 32'h0000_2003);
    check("read start latency", 64'(bus_req), 64'd1);
    respond(0, 1'b1, 1'b0, 32'hAABB_CCDD);
    dmi_rd(SBDATA, 32'h0000_00DD);
    dmi_rd(SBADDR, 32'h0000_2003);

    // Alignment and size errors; neither may produce a bus cycle.
    dmi_wr(SBCS, 32'h0014_0000);
    dmi_wr(SBADDR, 32'h0000_2002);
    dmi_rd(SBCS, 32'h2014_3407);
    dmi_wr(SBCS, 32'h0000_7000);
    dmi_rd(SBCS, 32'h2000_0407);
    dmi_wr(SBCS, 32'h0016_0000);
    dmi_wr(SBADDR, 32'h0000_3000);
    dmi_rd(SBCS, 32'h2016_4407);
    dmi_wr(SBCS, 32'h0004_7000);
    dmi_rd(SBCS, 32'h2004_0407);

    // Busy collision: second write rejected, then further starts blocked until cleared.
    expect_bus(1'b1, 32'h3000, 2'd2, 32'h1111_1111);
    dmi_wr(SBDATA, 32'h1111_1111);
    dmi_wr(SBDATA, 32'h2222_2222);
    respond(0, 1'b1, 1'b0, 32'h0);
    dmi_rd(SBDATA, 32'h1111_1111);
    dmi_rd(SBCS,   32'h2044_0407);
    dmi_wr(SBDATA, 32'h3333_3333);
    repeat (3) begin @(posedge clk); #1; end
    check("blocked start", 64'(bus_req), 64'd0);
    dmi_wr(SBCS, 32'h0044_0000);
    dmi_rd(SBCS, 32'h2004_0407);
    expect_bus(1'b1, 32'h3000, 2'd2, 32'h4444_4444);
    dmi_wr(SBDATA, 32'h4444_4444);
    respond(1, 1'b1, 1'b0, 32'h0);

    // Bus error with simultaneous ack: error wins, no data update, no autoincrement.
    dmi_wr(SBCS, 32'h0015_0000);
    expect_bus(1'b0, 32'h4000, 2'd2, 32'h0);
    dmi_wr(SBADDR, 32'h0000_4000);
    respond(1, 1'b1, 1'b1, 32'h5555_5555);
    dmi_rd(SBDATA, 32'h4444_4444);
    dmi_rd(SBADDR, 32'h0000_4000);
    dmi_rd(SBCS,   32'h2015_2407);
    dmi_wr(SBCS, 32'h0000_7000);

    // Half-word read with autoincrement by 2.
    dmi_wr(SBCS, 32'h0013_0000);
    expect_bus(1'b0, 32'h5006, 2'd1, 32'h0);
    dmi_wr(SBADDR, 32'h0000_5006);
    respond(0, 1'b1, 1'b0, 32'h1234_5678);
    dmi_rd(SBDATA, 32'h0000_5678);
    dmi_rd(SBADDR, 32'h0000_5008);

    // Word read at the top of the address space wraps to 0.
    dmi_wr(SBCS, 32'h0015_0000);
    expect_bus(1'b0, 32'hFFFF_FFFC, 2'd2, 32'h0);
    dmi_wr(SBADDR, 32'hFFFF_FFFC);
    respond(0, 1'b1, 1'b0, 32'hCAFE_F00D);
    dmi_rd(SBDATA, 32'hCAFE_F00D);
    dmi_rd(SBADDR, 32'h0000_0000);

`ifdef SBA_TIMEOUT_EN
    begin
      int n = 0;
      dmi_wr(SBCS, 32'h0004_0000);
      expect_bus(1'b1, 32'h0, 2'd2, 32'h0000_0BAD);
      dmi_wr(SBDATA, 32'h0000_0BAD);
      while (bus_req && n < 50) begin n++; @(posedge clk); #1; end
      have_cur = 1'b0;
      check("timeout cycles", 64'(n), 64'd8);
      dmi_rd(SBCS, 32'h2004_1407);
    end
`endif

    repeat (3) begin @(posedge clk); #1; end
    check("bus queue drained", 64'(exp_bus.size()), 64'd0);
    check("read queue drained", 64'(exp_rd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dm_sba_ctrl.md
# dm_sba_ctrl

System Bus Access (SBA) manager for the RISC-V debug module. It decodes debugger DMI accesses to `sbcs` (0x38), `sbaddress0` (0x39) and `sbdata0` (0x3c), then runs single 8/16/32-bit read or write transactions on the system bus through a request/acknowledge handshake. It owns the `sbcs_t` state: busy, busyerror, error, access size, autoincrement, readonaddr and readondata. It sits between the DMI register decoder and the system bus interconnect.

## Interface
- `ADDR_W`, 32, system bus address width; must be ≤ 32 so `sbaddress0` holds the whole address.
- `TIMEOUT_CYCLES`, 255, cycles to wait for `bus_ack`/`bus_err` before aborting (used only with `SBA_TIMEOUT_EN`).
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `dmi_valid` in 1: one-cycle DMI register access strobe.
- `dmi_write` in 1: 1 = write, 0 = read.
- `dmi_addr` in 8: register address, `debug::dcsr_e` encoding; other addresses are ignored.
- `dmi_wdata` in 32: write data.
- `dmi_rdata` out 32: read data; combinational in the same cycle as `dmi_valid`; 0 for unmapped addresses.
- `bus_req` out 1: transaction request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out ADDR_W: byte address.
- `bus_size` out 2: 0 = byte, 1 = half-word, 2 = word.
- `bus_wdata` out 32: write data, right-justified.
- `bus_ack` in 1: transaction done; read data valid.
- `bus_err` in 1: transaction failed.
- `bus_rdata` in 32: read data, right-justified; bits above the access size are ignored.
- `sb_busy` out 1: mirrors `sbcs.busy`, for status/abstract logic.

## Operation
- **States:**
  - IDLE.
  - BUSY: `bus_req`=1.
- **`sbcs` read fields:**
  - version = 1.
  - size = 32.
  - access8/16/32 = 1; access64/128 = 0.
  - busy = (state==BUSY).
- **`sbcs` write:**
  - Loads readonaddr, access, autoincrement, readondata.
  - busyerror and error are write-1-to-clear per bit.
  - Allowed while busy.
- **`sbaddress0` write:**
  - If busy: set busyerror; address unchanged.
  - Else: load the address. If readonaddr=1, start a read.
- **`sbdata0` write:**
  - If busy: set busyerror; data unchanged.
  - Else: load the data and start a write.
- **`sbdata0` read:**
  - If busy: set busyerror and return the current data.
  - Else: return the data. If readondata=1, start a read after the value is returned.
- **Start conditions:** a start is suppressed, with no state change, while error≠0 or busyerror=1.
- **Start checks:**
  - access>2: error←4 (size), no bus cycle.
  - Address misaligned for the access size: error←3 (alignment), no bus cycle.
  - Otherwise: IDLE→BUSY.
- **BUSY exit:**
  - `bus_err`: error←2; return to IDLE. `bus_err` wins if asserted together with `bus_ack`.
  - `bus_ack`: on a read, data←`bus_rdata` zero-extended from the access size. If autoincrement=1, address += 1<<access, wrapping modulo 2^ADDR_W. Return to IDLE.
- Autoincrement never applies after an error.

## Timing
- **Reset values:**
  - All outputs 0.
  - State IDLE; address and data 0.
  - access=2; all other `sbcs` RW fields 0; error=0; busyerror=0.
- **Start latency:** `bus_req` rises on the clock edge that samples the triggering DMI access, so it is visible one cycle later.
- **Bus handshake:**
  - `bus_req`, `bus_we`, `bus_addr`, `bus_size` and `bus_wdata` stay stable while `bus_req`=1.
  - `bus_req` drops on the edge that samples `bus_ack` or `bus_err`.
  - Minimum transaction: 2 cycles of `bus_req` cannot happen with zero-wait ack; the minimum is 1 cycle of `bus_req`.
- **Busy visibility:** busy and `sb_busy` are registered. A DMI access in the same cycle as `bus_ack` still sees busy=1 and sets busyerror.
- **Completion results:** read data and the incremented address are readable the cycle after the ack.
- **Reset mid-transaction:** `bus_req` deasserts after the reset edge. The interconnect must tolerate the abandoned request; a late `bus_ack` seen in IDLE is ignored.
- **Concurrent clear:** a W1C of error in the same cycle that a new error is generated leaves the new error set.

## Configuration
- `SBA_TIMEOUT_EN`
  - **Defined:** a counter clears on entry to BUSY and increments each BUSY cycle without ack or err. When it reaches TIMEOUT_CYCLES, error←1 (timeout), `bus_req` drops and state returns to IDLE.
  - **Undefined:** no counter; BUSY waits indefinitely and error=1 is never produced.

## Test plan
- **Write sequence:** write `sbcs` access=2, autoincrement=1; write `sbaddress0`=0x1000; write `sbdata0`=0xDEADBEEF; ack after 3 cycles.
  - Expect `bus_req`=1 with we=1, addr=0x1000, size=2, wdata=0xDEADBEEF.
  - Afterwards `sbaddress0` reads 0x1004 and busy=0.
- **Byte read:** access=0, readonaddr=1; write `sbaddress0`=0x2003; `bus_rdata`=0xAABBCCDD.
  - Expect bus addr=0x2003, size=0.
  - `sbdata0` then reads 0x000000DD.
- **Error paths:**
  - access=2 and `sbaddress0`=0x2002 with readonaddr → error=3, no `bus_req`.
  - access=3 → error=4.
  - Writing 0x7000 (error bits) to `sbcs` clears error.
- **Busy collision:** write `sbdata0` while BUSY → busyerror=1 and data unchanged.
  - The next `sbdata0` write issues no bus cycle until `sbcs` is written with busyerror=1 to clear it.
- **Bus error:** `bus_err` and `bus_ack` asserted together on a read → error=2, data unchanged, no autoincrement.
- **Timeout (with `SBA_TIMEOUT_EN`, TIMEOUT_CYCLES=8):** never ack → `bus_req` drops after 8 BUSY cycles and error=1.
